vertex_transform_sequencer: RTL and testbench

Sequenced, area-reduced vertex transform stage. It holds a 4x4 fixed-point matrix loaded row by row and accepts vertices over a valid/ready stream. It computes each output component with a single shared 4-lane dot-product unit, one component per cycle, then presents the transformed vertex on an output valid/ready stream. It sits between vertex fetch and clip/raster setup, in place of a fully parallel 16-multiplier transform.

---
 rtl/vertex_transform_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_vertex_transform_sequencer.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vertex_transform_sequencer.sv
// Sequenced 4x4 fixed-point vertex transform: one shared 4-lane dot product, one output component per cycle.
// Optional one-entry input skid buffer enabled by defining VERTEX_TRANSFORM_SKID_EN.

`ifndef FIXEDPOINT_WIDTH
`define FIXEDPOINT_WIDTH 32
`endif
`ifndef FIXEDPOINT_FRAC
`define FIXEDPOINT_FRAC 16
`endif

module vertex_transform_sequencer (
  input  logic                           i_clk,
  input  logic                           i_reset_n,
  input  logic                           i_matrix_row_valid,
  input  logic [1:0]                     i_matrix_row_index,
  input  logic [4*`FIXEDPOINT_WIDTH-1:0] i_matrix_row,
  output logic                           o_matrix_row_ready,
  input  logic                           i_vertex_valid,
  input  logic [4*`FIXEDPOINT_WIDTH-1:0] i_vertex,
  output logic                           o_vertex_ready,
  output logic                           o_vertex_valid,
  output logic [4*`FIXEDPOINT_WIDTH-1:0] o_vertex,
  input  logic                           i_vertex_ready,
  output logic                           o_busy
);

  localparam int W    = `FIXEDPOINT_WIDTH;
  localparam int FRAC = `FIXEDPOINT_FRAC;
  localparam int W2   = 2 * W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_OUTPUT  = 2'd2
  } state_e;

  // Signed fixed-point product, rounded toward minus infinity and truncated to W bits.
  function automatic logic [W-1:0] fixed_point_multiply(input logic signed [W-1:0] a,
                                                        input logic signed [W-1:0] b);
    logic signed [W2-1:0] p;
    p = W2'(a) * W2'(b);
    return W'(p >>> FRAC);
  endfunction

  // Row and vertex are packed {x,y,z,w}; the sum wraps modulo 2^W.
  function automatic logic [W-1:0] dot_product(input logic [4*W-1:0] row,
                                               input logic [4*W-1:0] vert);
    logic [W-1:0] sum;
    sum = '0;
    for (int j = 0; j < 4; j++) begin
      sum = sum + fixed_point_multiply(row[(3-j)*W +: W], vert[(3-j)*W +: W]);
    end
    return sum;
  endfunction

  state_e         state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [4*W-1:0] work_q, work_d;
  logic [W-1:0]   result_q [4];
  logic [W-1:0]   result_d [4];
  logic [4*W-1:0] matrix_q [4];
  logic           valid_q, valid_d;
  logic           matrix_we;
  logic           row_ready;
  logic           vtx_ready;
  logic           skid_full;

`ifdef VERTEX_TRANSFORM_SKID_EN
  logic [4*W-1:0] skid_q, skid_d;
  logic           skid_full_q, skid_full_d;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      skid_q      <= '0;
      skid_full_q <= 1'b0;
    end else begin
      skid_q      <= skid_d;
      skid_full_q <= skid_full_d;
    end
  end

  assign skid_full = skid_full_q;
`else
  assign skid_full = 1'b0;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    result_d  = result_q;
    matrix_we = 1'b0;
    row_ready = 1'b0;
    vtx_ready = 1'b0;
`ifdef VERTEX_TRANSFORM_SKID_EN
    skid_d      = skid_q;
    skid_full_d = skid_full_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
`ifdef VERTEX_TRANSFORM_SKID_EN
        if (skid_full_q) begin
          work_d      = skid_q;
          skid_full_d = 1'b0;
          cnt_d       = 2'd0;
          state_d     = ST_COMPUTE;
        end else
`endif
        begin
          row_ready = 1'b1;
          if (i_matrix_row_valid) begin
            matrix_we = 1'b1;
          end else begin
            vtx_ready = 1'b1;
            if (i_vertex_valid) begin
              work_d  = i_vertex;
              cnt_d   = 2'd0;
              state_d = ST_COMPUTE;
            end
          end
        end
      end

      ST_COMPUTE: begin
        result_d[cnt_q] = dot_product(matrix_q[cnt_q], work_q);
        cnt_d           = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = ST_OUTPUT;
      end

      ST_OUTPUT: begin
        if (i_vertex_ready) begin
`ifdef VERTEX_TRANSFORM_SKID_EN
          if (skid_full_q) begin
            work_d      = skid_q;
            skid_full_d = 1'b0;
            cnt_d       = 2'd0;
            state_d     = ST_COMPUTE;
          end else
`endif
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

`ifdef VERTEX_TRANSFORM_SKID_EN
    // Buffer refills are only offered while the buffer is empty, so fill and drain never collide.
    if (state_q != ST_IDLE && !skid_full_q) begin
      vtx_ready = 1'b1;
      if (i_vertex_valid) begin
        skid_d      = i_vertex;
        skid_full_d = 1'b1;
      end
    end
`endif

    valid_d = (state_d == ST_OUTPUT);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      work_q  <= '0;
      valid_q <= 1'b0;
      // NOTE: the matrix and result arrays must read zero after reset, so they are reset flops, not RAM.
      for (int r = 0; r < 4; r++) begin
        matrix_q[r] <= '0;
        result_q[r] <= '0;
      end
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments only.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      if (matrix_we) matrix_q[i_matrix_row_index] <= i_matrix_row;
    end
  end

  // Readies are gated by reset so every output reads zero while reset is held.
  assign o_matrix_row_ready = row_ready & i_reset_n;
  assign o_vertex_ready     = vtx_ready & i_reset_n;
  assign o_vertex_valid     = valid_q;
  assign o_vertex           = {result_q[0], result_q[1], result_q[2], result_q[3]};
  assign o_busy             = (state_q != ST_IDLE) | skid_full;

endmodule

// File: tb/tb_vertex_transform_sequencer.sv
// Self-checking bench for vertex_transform_sequencer: scoreboard fed by a matrix-product reference model.
// Define VERTEX_TRANSFORM_SKID_EN for both files to exercise the skid-buffer build.

module tb_vertex_transform_sequencer;

  localparam int ONE = 65536;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_matrix_row_valid;
  logic [1:0]   i_matrix_row_index;
  logic [127:0] i_matrix_row;
  logic         o_matrix_row_ready;
  logic         i_vertex_valid;
  logic [127:0] i_vertex;
  logic         o_vertex_ready;
  logic         o_vertex_valid;
  logic [127:0] o_vertex;
  logic         i_vertex_ready;
  logic         o_busy;

  vertex_transform_sequencer dut (
    .i_clk              (clk),
    .i_reset_n          (rst_n),
    .i_matrix_row_valid (i_matrix_row_valid),
    .i_matrix_row_index (i_matrix_row_index),
    .i_matrix_row       (i_matrix_row),
    .o_matrix_row_ready (o_matrix_row_ready),
    .i_vertex_valid     (i_vertex_valid),
    .i_vertex           (i_vertex),
    .o_vertex_ready     (o_vertex_ready),
    .o_vertex_valid     (o_vertex_valid),
    .o_vertex           (o_vertex),
    .i_vertex_ready     (i_vertex_ready),
    .o_busy             (o_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Reference model: matrix as plain integers, Q16.16 products with floor, sums wrapped to 32 bits.
  int model_m [4][4];

  function automatic int fx_mul(input int a, input int b);
    longint p;
    p = longint'(a) * longint'(b);
    return int'(p >>> 16);
  endfunction

  function automatic int comp(input logic [127:0] v, input int j);
    return int'(v[(3-j)*32 +: 32]);
  endfunction

  function automatic logic [127:0] vec(input int x, input int y, input int z, input int w);
    return {x, y, z, w};
  endfunction

  function automatic logic [127:0] transform(input logic [127:0] v);
    logic [127:0] r;
    longint s;
    for (int k = 0; k < 4; k++) begin
      s = 0;
      for (int j = 0; j < 4; j++) s += longint'(fx_mul(model_m[k][j], comp(v, j)));
      r[(3-k)*32 +: 32] = s[31:0];
    end
    return r;
  endfunction

  // Scoreboard: expected results pushed at vertex acceptance, popped at output handshake.
  logic [127:0] exp_q[$];
  int           acc_times[$];
  int           last_acc  = 0;
  int           last_rise = 0;
  int           rises     = 0;
  bit           prev_valid = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (i_matrix_row_valid && o_matrix_row_ready)
        for (int j = 0; j < 4; j++) model_m[i_matrix_row_index][j] = comp(i_matrix_row, j);
      if (i_vertex_valid && o_vertex_ready) begin
        exp_q.push_back(transform(i_vertex));
        acc_times.push_back(cyc + 1);
        last_acc = cyc + 1;
      end
      if (o_vertex_valid && !prev_valid) begin
        last_rise = cyc;
        rises++;
      end
      if (o_vertex_valid && i_vertex_ready) begin
        if (exp_q.size() == 0) timeout("sb_unexpected_output");
        else check("sb_vertex", o_vertex, exp_q.pop_front());
      end
      prev_valid = o_vertex_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  bit rand_bp = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rand_bp) i_vertex_ready = 1'($urandom_range(0, 1));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_row(input int idx, input logic [127:0] row);
    i_matrix_row_valid = 1'b1;
    i_matrix_row_index = 2'(idx);
    i_matrix_row       = row;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (o_matrix_row_ready) begin
        tick();
        i_matrix_row_valid = 1'b0;
        return;
      end
    end
    timeout("row_write");
    i_matrix_row_valid = 1'b0;
  endtask

  task automatic load4(input logic [127:0] r0, input logic [127:0] r1,
                       input logic [127:0] r2, input logic [127:0] r3);
    write_row(0, r0);
    write_row(1, r1);
    write_row(2, r2);
    write_row(3, r3);
  endtask

  task automatic send_vertex(input logic [127:0] v);
    i_vertex_valid = 1'b1;
    i_vertex       = v;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (o_vertex_ready) begin
        tick();
        i_vertex_valid = 1'b0;
        return;
      end
    end
    timeout("vertex_send");
    i_vertex_valid = 1'b0;
  endtask

  task automatic wait_valid();
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (o_vertex_valid) begin
        #1;
        return;
      end
    end
    timeout("wait_valid");
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (!o_busy && !o_vertex_valid) begin
        tick();
        return;
      end
    end
    timeout("wait_idle");
  endtask

  task automatic load_translate();
    load4(vec(ONE, 0, 0, ONE), vec(0, ONE, 0, 2*ONE), vec(0, 0, ONE, 3*ONE), vec(0, 0, 0, ONE));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  logic [127:0] snap;
  logic [127:0] v_id;
  int           n;
  int           r0;
  int           exp_gap;

  initial begin
    for (int k = 0; k < 4; k++) for (int j = 0; j < 4; j++) model_m[k][j] = 0;
    rst_n              = 1'b0;
    i_matrix_row_valid = 1'b1;
    i_matrix_row_index = 2'd0;
    i_matrix_row       = '0;
    i_vertex_valid     = 1'b1;
    i_vertex           = vec(ONE, ONE, ONE, ONE);
    i_vertex_ready     = 1'b1;

    // Reset with requests pending: every output reads zero.
    #23;
    check("rst_vertex_valid", o_vertex_valid, 0);
    check("rst_vertex", o_vertex, 0);
    check("rst_vertex_ready", o_vertex_ready, 0);
    check("rst_row_ready", o_matrix_row_ready, 0);
    check("rst_busy", o_busy, 0);
    i_matrix_row_valid = 1'b0;
    i_vertex_valid     = 1'b0;
    rst_n              = 1'b1;
    #1;
    check("idle_vertex_ready", o_vertex_ready, 1);
    check("idle_row_ready", o_matrix_row_ready, 1);
    tick();

    // Identity transform and 4-cycle latency.
    load4(vec(ONE, 0, 0, 0), vec(0, ONE, 0, 0), vec(0, 0, ONE, 0), vec(0, 0, 0, ONE));
    v_id = vec(2*ONE, -3*ONE, ONE/2, ONE);
    send_vertex(v_id);
    wait_valid();
    check("identity_latency", last_rise - last_acc, 4);
    check("identity_value", o_vertex, v_id);
    wait_idle();

    // Zero matrix.
    load4('0, '0, '0, '0);
    send_vertex(v_id);
    wait_valid();
    check("zero_value", o_vertex, 0);
    wait_idle();

    // Translation by (1,2,3).
    load_translate();
    send_vertex(vec(ONE, ONE, ONE, ONE));
    wait_valid();
    check("translate_value", o_vertex, vec(2*ONE, 3*ONE, 4*ONE, ONE));
    wait_idle();

    // Backpressure: output held, stable, matrix writes refused.
    i_vertex_ready = 1'b0;
    send_vertex(vec(-ONE, 5*ONE, 0, ONE));
    wait_valid();
    snap = o_vertex;
    check("bp_value", snap, vec(0, 7*ONE, 3*ONE, ONE));
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      check("bp_valid", o_vertex_valid, 1);
      check("bp_stable", o_vertex, snap);
      check("bp_row_ready", o_matrix_row_ready, 0);
    end
    tick();
    i_vertex_ready = 1'b1;
    wait_idle();

    // Row write and vertex together in IDLE: row wins, vertex uses the new row next cycle.
    i_matrix_row_valid = 1'b1;
    i_matrix_row_index = 2'd0;
    i_matrix_row       = vec(2*ONE, 0, 0, ONE);
    i_vertex_valid     = 1'b1;
    i_vertex           = vec(ONE, ONE, ONE, ONE);
    #1;
    check("prio_vertex_ready", o_vertex_ready, 0);
    check("prio_row_ready", o_matrix_row_ready, 1);
    tick();
    i_matrix_row_valid = 1'b0;
    #1;
    check("prio_vertex_ready_next", o_vertex_ready, 1);
    tick();
    i_vertex_valid = 1'b0;
    wait_valid();
    check("prio_value", o_vertex, vec(3*ONE, 3*ONE, 4*ONE, ONE));
    wait_idle();

    // Back-to-back stream of 8 vertices under a random matrix.
    load4({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
          {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    acc_times.delete();
    n              = 0;
    i_vertex       = {$urandom, $urandom, $urandom, $urandom};
    i_vertex_valid = 1'b1;
    for (int t = 0; t < 400 && n < 8; t++) begin
      @(negedge clk);
      if (o_vertex_ready) begin
        tick();
        n++;
        if (n < 8) i_vertex = {$urandom, $urandom, $urandom, $urandom};
        else i_vertex_valid = 1'b0;
      end
    end
    i_vertex_valid = 1'b0;
    check("stream_accepts", acc_times.size(), 8);
    wait_idle();
`ifdef VERTEX_TRANSFORM_SKID_EN
    exp_gap = 5;
`else
    exp_gap = 6;
`endif
    for (int i = 1; i < acc_times.size(); i++) begin
`ifdef VERTEX_TRANSFORM_SKID_EN
      if (i == 1) continue;
`endif
      check("stream_interval", acc_times[i] - acc_times[i-1], exp_gap);
    end

    // Random matrices and vertices with random backpressure.
    rand_bp = 1'b1;
    for (int m = 0; m < 3; m++) begin
      for (int r = 0; r < 4; r++)
        write_row(r, {$urandom_range(0, 4*ONE), $urandom, $urandom_range(0, 4*ONE), $urandom});
      for (int k = 0; k < 6; k++) begin
        send_vertex({$urandom, $urandom, $urandom, $urandom});
        repeat ($urandom_range(0, 3)) tick();
      end
    end
    rand_bp = 1'b0;
    tick();
    i_vertex_ready = 1'b1;
    wait_idle();

    // Reset on cycle 2 of COMPUTE: in-flight vertex discarded, next one correct.
    load_translate();
    send_vertex(vec(ONE, ONE, ONE, ONE));
    tick();
    tick();
    rst_n = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 4; k++) for (int j = 0; j < 4; j++) model_m[k][j] = 0;
    #1;
    check("midrst_valid", o_vertex_valid, 0);
    check("midrst_busy", o_busy, 0);
    tick();
    tick();
    rst_n = 1'b1;
    r0 = rises;
    repeat (8) tick();
    check("midrst_no_pulse", rises - r0, 0);
    load_translate();
    send_vertex(vec(2*ONE, 0, -ONE, ONE));
    wait_valid();
    check("midrst_next_value", o_vertex, vec(3*ONE, 2*ONE, 2*ONE, ONE));
    wait_idle();

    check("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
